// File: rtl/term_write_sched.sv
// Single write-port scheduler for the VGA text terminal: merges buffered keyboard
// echo with locked command-response bursts, closing each burst with ENTER_CODE.
module term_write_sched #(
  parameter int          ECHO_DEPTH = 8,
  parameter logic [7:0]  ENTER_CODE = 8'h0D
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          echo_valid,
  input  logic [7:0]                    echo_data,
  output logic                          echo_ready,
  output logic                          echo_drop,
  input  logic                          rsp_valid,
  input  logic [7:0]                    rsp_data,
  input  logic                          rsp_last,
  output logic                          rsp_ready,
  input  logic                          disp_busy,
  output logic                          disp_en,
  output logic [7:0]                    disp_ascii,
  output logic                          rsp_active,
  output logic [$clog2(ECHO_DEPTH):0]   echo_count
);

  localparam int AW = $clog2(ECHO_DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(ECHO_DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ECHO,
    S_RSP,
    S_RSP_ENTER
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      fifo_mem [ECHO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            disp_en_reg;
  logic [7:0]      disp_ascii_reg;
  logic            rsp_active_reg, rsp_active_next;

  logic            slot_free;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            issue;
  logic [7:0]      issue_code;
  logic            rsp_take;

  // A write may only be launched when the display is free and no strobe is in flight,
  // which guarantees an idle cycle between consecutive strobes.
  assign slot_free  = !disp_busy && !disp_en_reg;
  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);

  assign echo_ready = !fifo_full && !rst;
  assign echo_drop  = echo_valid && fifo_full && !rst;
  assign push       = echo_valid && echo_ready;
  assign rsp_ready  = rsp_take && !rst;

  always_comb begin
    state_next      = state_reg;
    rsp_active_next = rsp_active_reg;
    issue           = 1'b0;
    issue_code      = fifo_mem[rd_ptr_reg];
    pop             = 1'b0;
    rsp_take        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (rsp_valid) begin
          state_next      = S_RSP;
          rsp_active_next = 1'b1;
        end else if (!fifo_empty && slot_free) begin
          issue      = 1'b1;
          pop        = 1'b1;
          state_next = S_ECHO;
        end
      end
      S_ECHO: begin
        // One echo character per arbitration keeps response wait bounded.
        state_next = S_IDLE;
      end
      S_RSP: begin
        if (rsp_valid && slot_free) begin
          rsp_take   = 1'b1;
          issue      = 1'b1;
          issue_code = rsp_data;
          if (rsp_last) begin
            state_next = S_RSP_ENTER;
          end
        end
      end
      S_RSP_ENTER: begin
        if (slot_free) begin
          issue           = 1'b1;
          issue_code      = ENTER_CODE;
          rsp_active_next = 1'b0;
          state_next      = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= echo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      disp_en_reg    <= 1'b0;
      disp_ascii_reg <= 8'h00;
      rsp_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rsp_active_reg <= rsp_active_next;
      disp_en_reg    <= issue;
      if (issue) begin
        disp_ascii_reg <= issue_code;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign disp_en    = disp_en_reg;
  assign disp_ascii = disp_ascii_reg;
  assign rsp_active = rsp_active_reg;
  assign echo_count = count_reg;

endmodule

// File: tb/tb_term_write_sched.sv
// Scoreboard bench for term_write_sched: expected display codes are queued as
// stimulus is driven and popped by a monitor on every write strobe.
module tb_term_write_sched;

  localparam logic [7:0] ENTER = 8'h0D;

  logic       clk;
  logic       rst;
  logic       echo_valid;
  logic [7:0] echo_data;
  logic       echo_ready;
  logic       echo_drop;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       rsp_ready;
  logic       disp_busy;
  logic       disp_en;
  logic [7:0] disp_ascii;
  logic       rsp_active;
  logic [3:0] echo_count;

  term_write_sched #(
    .ECHO_DEPTH (8),
    .ENTER_CODE (ENTER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .echo_valid (echo_valid),
    .echo_data  (echo_data),
    .echo_ready (echo_ready),
    .echo_drop  (echo_drop),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .rsp_ready  (rsp_ready),
    .disp_busy  (disp_busy),
    .disp_en    (disp_en),
    .disp_ascii (disp_ascii),
    .rsp_active (rsp_active),
    .echo_count (echo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] exp_byte;
  logic       prev_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every strobe must be isolated and match the queue head.
  always @(negedge clk) begin
    if (disp_en === 1'b1) begin
      check("strobe_gap", prev_en, 0);
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_byte = exp_q.pop_front();
        check("strobe_ascii", disp_ascii, exp_byte);
      end
      $display("strobe ascii=0x%02h t=%0t", disp_ascii, $time);
    end
    prev_en = disp_en;
  end

  task automatic send_rsp(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    rsp_valid = 1'b1;
    rsp_data  = d;
    rsp_last  = l;
    @(negedge clk);
    while (rsp_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_ready_bound", n < 50, 1);
    exp_q.push_back(d);
    if (l) exp_q.push_back(ENTER);
    tick();
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
  endtask

  task automatic flush_pend();
    while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_active !== 1'b0 || echo_count != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", n < 100, 1);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; echo_valid = 1'b1; echo_data = 8'h21;
    rsp_valid = 1'b1; rsp_data = 8'h22; rsp_last = 1'b0; disp_busy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_echo_ready", echo_ready, 0);
    check("rst_rsp_ready", rsp_ready, 0);
    check("rst_echo_drop", echo_drop, 0);
    tick();
    rst = 1'b0; echo_valid = 1'b0; rsp_valid = 1'b0;
    @(negedge clk);
    check("rv_disp_en", disp_en, 0);
    check("rv_disp_ascii", disp_ascii, 8'h00);
    check("rv_rsp_active", rsp_active, 0);
    check("rv_echo_drop", echo_drop, 0);
    check("rv_echo_count", echo_count, 0);
    check("rv_echo_ready", echo_ready, 1);
    tick();

    // Echo only, with first-strobe latency of two cycles.
    echo_valid = 1'b1; echo_data = 8'h41; exp_q.push_back(8'h41);
    @(negedge clk);
    check("echo_lat_t0", disp_en, 0);
    tick();
    echo_data = 8'h42; exp_q.push_back(8'h42);
    @(negedge clk);
    check("echo_lat_t1", disp_en, 0);
    tick();
    echo_data = 8'h43; exp_q.push_back(8'h43);
    @(negedge clk);
    check("echo_lat_t2_en", disp_en, 1);
    check("echo_lat_t2_ascii", disp_ascii, 8'h41);
    tick();
    echo_valid = 1'b0;
    wait_drain();

    // Response burst with explicit lock / ready / strobe timing.
    rsp_valid = 1'b1; rsp_data = 8'h4F; rsp_last = 1'b0;
    @(negedge clk);
    check("lock_ready", rsp_ready, 0);
    check("lock_active", rsp_active, 0);
    tick();
    @(negedge clk);
    check("rsp_active_set", rsp_active, 1);
    check("rsp_ready_lat", rsp_ready, 1);
    exp_q.push_back(8'h4F);
    tick();
    rsp_data = 8'h4B; rsp_last = 1'b1;
    @(negedge clk);
    check("rsp_strobe_lat", disp_en, 1);
    check("rsp_ready_gap", rsp_ready, 0);
    send_rsp(8'h4B, 1'b1);
    n = 0;
    @(negedge clk);
    while (rsp_active !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("active_release_bound", n < 10, 1);
    check("active_release_en", disp_en, 1);
    check("active_release_ascii", disp_ascii, ENTER);
    wait_drain();

    // Contention: response raised during the first echo strobe.
    echo_valid = 1'b1; echo_data = 8'h61; exp_q.push_back(8'h61);
    tick();
    echo_data = 8'h62; pend_q.push_back(8'h62);
    tick();
    echo_data = 8'h63; pend_q.push_back(8'h63);
    rsp_valid = 1'b1; rsp_data = 8'h58; rsp_last = 1'b1;
    @(negedge clk);
    check("cont_first_echo", disp_en, 1);
    tick();
    echo_valid = 1'b0;
    send_rsp(8'h58, 1'b1);
    flush_pend();
    wait_drain();

    // Overflow while a response holds the lock with no data offered.
    rsp_valid = 1'b1; rsp_data = 8'h5A; rsp_last = 1'b0;
    @(negedge clk);
    check("ovf_lock_ready", rsp_ready, 0);
    tick();
    rsp_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      echo_valid = 1'b1;
      echo_data  = 8'h30 + 8'(i);
      if (i < 8) pend_q.push_back(8'h30 + 8'(i));
      @(negedge clk);
      check("ovf_drop", echo_drop, (i >= 8));
      check("ovf_count", echo_count, (i < 8) ? i : 8);
      tick();
    end
    echo_valid = 1'b0;
    @(negedge clk);
    check("ovf_final_count", echo_count, 8);
    check("ovf_final_ready", echo_ready, 0);
    check("ovf_final_drop", echo_drop, 0);
    check("ovf_stalled_ready", rsp_ready, 0);
    tick();
    send_rsp(8'h5A, 1'b1);
    flush_pend();
    wait_drain();

    // Backpressure: display busy for 5 cycles mid-burst.
    send_rsp(8'h70, 1'b0);
    rsp_valid = 1'b1; rsp_data = 8'h71; rsp_last = 1'b0;
    @(negedge clk);
    tick();
    disp_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_no_strobe", disp_en, 0);
      check("bp_no_ready", rsp_ready, 0);
      tick();
    end
    disp_busy = 1'b0;
    send_rsp(8'h71, 1'b0);
    send_rsp(8'h72, 1'b1);
    wait_drain();

    // Reset after the first of three response characters.
    rsp_valid = 1'b1; rsp_data = 8'h44; rsp_last = 1'b0;
    echo_valid = 1'b1; echo_data = 8'h55;
    tick();
    echo_valid = 1'b0;
    send_rsp(8'h44, 1'b0);
    rst = 1'b1;
    rsp_valid = 1'b1; rsp_data = 8'h45;
    @(negedge clk);
    check("mid_pre_count", echo_count, 1);
    check("mid_rst_echo_ready", echo_ready, 0);
    check("mid_rst_rsp_ready", rsp_ready, 0);
    tick();
    rst = 1'b0; rsp_valid = 1'b0;
    @(negedge clk);
    check("mid_disp_en", disp_en, 0);
    check("mid_disp_ascii", disp_ascii, 8'h00);
    check("mid_rsp_active", rsp_active, 0);
    check("mid_echo_count", echo_count, 0);
    check("mid_echo_drop", echo_drop, 0);
    check("mid_echo_ready", echo_ready, 1);
    repeat (12) tick();

    check("leftover_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
